// File: rtl/k12a_gp_regfile_pkg.sv
// Shared K12A register-file types: write-source and pair-operation encodings,
// plus the default datapath geometry.
package k12a_gp_regfile_pkg;

   localparam int GP_DATA_W   = 8;
   localparam int GP_NUM_REGS = 4;

   typedef enum logic {
      GP_WR_DATA_BUS = 1'b0,
      GP_WR_ADDR_BUS = 1'b1
   } gp_wr_src_t;

   typedef enum logic [1:0] {
      GP_PAIR_NONE = 2'd0,
      GP_PAIR_INC  = 2'd1,
      GP_PAIR_DEC  = 2'd2
   } gp_pair_op_t;

   // Select widths never collapse to zero bits, even for a single pair.
   function automatic int gp_min1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/k12a_gp_regfile_pair_incdec.sv
// Combinational register-pair increment/decrement; wrap flags the carry out of
// INC from all-ones or the borrow out of DEC from zero.
module k12a_gp_pair_incdec
   import k12a_gp_regfile_pkg::*;
#(
   parameter int ADDR_W = 2 * GP_DATA_W
) (
   input  logic [ADDR_W-1:0] pair_in,
   input  gp_pair_op_t       op,
   output logic [ADDR_W-1:0] pair_out,
   output logic              wrap
);

   // Extend by one bit so the top bit is the carry/borrow.
   always_comb begin
      pair_out = pair_in;
      wrap     = 1'b0;
      case (op)
         GP_PAIR_INC: {wrap, pair_out} = {1'b0, pair_in} + {{ADDR_W{1'b0}}, 1'b1};
         GP_PAIR_DEC: {wrap, pair_out} = {1'b0, pair_in} - {{ADDR_W{1'b0}}, 1'b1};
         default: begin
            pair_out = pair_in;
            wrap     = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/k12a_gp_regfile.sv
// K12A general-purpose register file: indexed bus reads/writes, pair inc/dec with
// wrap, and an optional shadow bank enabled by K12A_GP_REGFILE_SHADOW_EN.
module k12a_gp_regfile
   import k12a_gp_regfile_pkg::*;
#(
   parameter  int DATA_W    = GP_DATA_W,
   parameter  int NUM_REGS  = GP_NUM_REGS,
   parameter  int SEL_W     = $clog2(NUM_REGS),
   localparam int ADDR_W    = 2 * DATA_W,
   localparam int NUM_PAIRS = NUM_REGS / 2,
   localparam int PSEL_W    = gp_min1($clog2(NUM_PAIRS))
) (
   input  logic                       cpu_clock,
   input  logic                       reset_n,
   input  logic                       rd_en_n,
   input  logic [SEL_W-1:0]           rd_sel,
   input  logic                       pair_rd_en_n,
   input  logic [PSEL_W-1:0]          pair_rd_sel,
   input  logic                       wr_en,
   input  gp_wr_src_t                 wr_src,
   input  logic [SEL_W-1:0]           wr_sel,
   input  gp_pair_op_t                pair_op,
   input  logic [PSEL_W-1:0]          pair_op_sel,
   input  logic                       bank_swap,
   inout  wire  [DATA_W-1:0]          data_bus,
   inout  wire  [ADDR_W-1:0]          addr_bus,
   output logic [NUM_REGS*DATA_W-1:0] regs,
   output logic                       bank,
   output logic                       pair_wrap
);

   logic [DATA_W-1:0] pri_r [NUM_REGS];
   logic [DATA_W-1:0] act_s [NUM_REGS];
   logic [DATA_W-1:0] nxt_s [NUM_REGS];
   logic [DATA_W-1:0] rd_data_s;
   logic [ADDR_W-1:0] rd_pair_s;
   logic [ADDR_W-1:0] op_in_s;
   logic [ADDR_W-1:0] op_out_s;
   logic [SEL_W-1:0]  wr_even_s;
   logic              op_wrap_s;
   logic              op_hit_s;
   logic              collide_s;
   logic              op_apply_s;
   logic              wrap_nxt_s;
   logic              pair_wrap_r;

`ifdef K12A_GP_REGFILE_SHADOW_EN
   logic [DATA_W-1:0] shd_r [NUM_REGS];
   logic              bank_r;

   // Active-bank view of the storage.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) act_s[i] = bank_r ? shd_r[i] : pri_r[i];
   end

   // Shadow bank takes the next-state image only while it is active.
   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) shd_r[i] <= {DATA_W{1'b0}};
      end else begin
         for (int i = 0; i < NUM_REGS; i++) shd_r[i] <= bank_r ? nxt_s[i] : shd_r[i];
      end
   end

   // Bank toggle; same-edge updates already target the old bank.
   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) bank_r <= 1'b0;
      else          bank_r <= bank_r ^ bank_swap;
   end

   assign bank = bank_r;

   // Primary bank takes the next-state image only while it is active.
   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) pri_r[i] <= {DATA_W{1'b0}};
      end else begin
         for (int i = 0; i < NUM_REGS; i++) pri_r[i] <= bank_r ? pri_r[i] : nxt_s[i];
      end
   end
`else
   logic unused_bank_swap_s;
   assign unused_bank_swap_s = bank_swap;
   assign bank               = 1'b0;

   // Single bank: the primary storage is always the active view.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) act_s[i] = pri_r[i];
   end

   // Primary bank register update.
   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) pri_r[i] <= {DATA_W{1'b0}};
      end else begin
         for (int i = 0; i < NUM_REGS; i++) pri_r[i] <= nxt_s[i];
      end
   end
`endif

   // Indexed read muxes; a select matching no register reads as zero.
   always_comb begin
      rd_data_s = {DATA_W{1'b0}};
      rd_pair_s = {ADDR_W{1'b0}};
      for (int i = 0; i < NUM_REGS; i++)
         rd_data_s = (rd_sel == SEL_W'(i)) ? act_s[i] : rd_data_s;
      for (int p = 0; p < NUM_PAIRS; p++)
         rd_pair_s = (pair_rd_sel == PSEL_W'(p)) ? {act_s[2*p], act_s[2*p+1]} : rd_pair_s;
   end

   assign data_bus = rd_en_n      ? {DATA_W{1'bz}} : rd_data_s;
   assign addr_bus = pair_rd_en_n ? {ADDR_W{1'bz}} : rd_pair_s;

   // Pair-op operand select and write-collision detection.
   always_comb begin
      op_in_s   = {ADDR_W{1'b0}};
      op_hit_s  = 1'b0;
      collide_s = 1'b0;
      wr_even_s = wr_sel & ~SEL_W'(1);
      for (int p = 0; p < NUM_PAIRS; p++) begin
         op_in_s   = (pair_op_sel == PSEL_W'(p)) ? {act_s[2*p], act_s[2*p+1]} : op_in_s;
         op_hit_s  = (pair_op_sel == PSEL_W'(p)) ? 1'b1 : op_hit_s;
         collide_s = (pair_op_sel == PSEL_W'(p)) ? (wr_en && (wr_even_s == SEL_W'(2*p))) : collide_s;
      end
      op_apply_s = op_hit_s && !collide_s && (pair_op != GP_PAIR_NONE);
   end

   k12a_gp_pair_incdec #(
      .ADDR_W   (ADDR_W)
   ) u_incdec (
      .pair_in  (op_in_s),
      .op       (pair_op),
      .pair_out (op_out_s),
      .wrap     (op_wrap_s)
   );

   // Next-state image of the active bank: pair op first, a bus write overrides it.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) nxt_s[i] = act_s[i];
      for (int p = 0; p < NUM_PAIRS; p++) begin
         nxt_s[2*p]   = (op_apply_s && (pair_op_sel == PSEL_W'(p))) ? op_out_s[ADDR_W-1:DATA_W] : nxt_s[2*p];
         nxt_s[2*p+1] = (op_apply_s && (pair_op_sel == PSEL_W'(p))) ? op_out_s[DATA_W-1:0]      : nxt_s[2*p+1];
      end
      wrap_nxt_s = op_apply_s & op_wrap_s;
      case ({wr_en, wr_src})
         {1'b1, GP_WR_DATA_BUS}: begin
            for (int i = 0; i < NUM_REGS; i++)
               nxt_s[i] = (wr_sel == SEL_W'(i)) ? data_bus : nxt_s[i];
         end
         {1'b1, GP_WR_ADDR_BUS}: begin
            for (int p = 0; p < NUM_PAIRS; p++) begin
               nxt_s[2*p]   = (wr_even_s == SEL_W'(2*p)) ? addr_bus[ADDR_W-1:DATA_W] : nxt_s[2*p];
               nxt_s[2*p+1] = (wr_even_s == SEL_W'(2*p)) ? addr_bus[DATA_W-1:0]      : nxt_s[2*p+1];
            end
         end
         default: wrap_nxt_s = op_apply_s & op_wrap_s;
      endcase
   end

   // Wrap flag is a one-cycle registered pulse.
   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) pair_wrap_r <= 1'b0;
      else          pair_wrap_r <= wrap_nxt_s;
   end

   assign pair_wrap = pair_wrap_r;

   // Flatten the active bank onto the regs port.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) regs[i*DATA_W +: DATA_W] = act_s[i];
   end

endmodule

// File: tb/tb_k12a_gp_regfile.sv
// Scoreboard bench for k12a_gp_regfile: directed scenarios then random traffic,
// checked against an array-level reference model.
module tb_k12a_gp_regfile;
   import k12a_gp_regfile_pkg::*;

   logic        cpu_clock = 1'b0;
   logic        reset_n;
   logic        rd_en_n, pair_rd_en_n, wr_en, bank_swap;
   logic [1:0]  rd_sel, wr_sel;
   logic        pair_rd_sel, pair_op_sel;
   gp_wr_src_t  wr_src;
   gp_pair_op_t pair_op;
   wire  [7:0]  data_bus;
   wire  [15:0] addr_bus;
   logic [31:0] regs;
   logic        bank, pair_wrap;
   logic [7:0]  tb_d;
   logic [15:0] tb_a;
   logic        tb_d_en, tb_a_en;

   assign data_bus = tb_d_en ? tb_d : 8'hzz;
   assign addr_bus = tb_a_en ? tb_a : 16'hzzzz;

   always #5 cpu_clock = ~cpu_clock;

   k12a_gp_regfile dut (
      .cpu_clock(cpu_clock), .reset_n(reset_n), .rd_en_n(rd_en_n), .rd_sel(rd_sel),
      .pair_rd_en_n(pair_rd_en_n), .pair_rd_sel(pair_rd_sel), .wr_en(wr_en),
      .wr_src(wr_src), .wr_sel(wr_sel), .pair_op(pair_op), .pair_op_sel(pair_op_sel),
      .bank_swap(bank_swap), .data_bus(data_bus), .addr_bus(addr_bus),
      .regs(regs), .bank(bank), .pair_wrap(pair_wrap)
   );

   typedef struct {
      bit         we;
      bit         src;
      logic [1:0] ws;
      logic [7:0] wd;
      logic [15:0] wa;
      logic [1:0] op;
      logic       os;
      bit         sw;
      bit         rde;
      logic [1:0] rs;
      bit         pre;
      logic       prs;
   } stim_t;

   typedef struct {
      logic [31:0] regs;
      logic        bank;
      logic        wrap;
      bit          chk_d;
      logic [7:0]  d;
      bit          chk_a;
      logic [15:0] a;
   } exp_t;

   exp_t q[$];
   int   total  = 0;
   int   passed = 0;

   // Reference model: two banks of four bytes, active bank index, wrap flag.
   logic [7:0] mr [2][4];
   int         mb;
   logic       mwrap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h expected=%h", name, act, exp);
   endtask

   function automatic void model_reset();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 4; i++) mr[b][i] = 8'h00;
      mb    = 0;
      mwrap = 1'b0;
   endfunction

   function automatic void push_exp(input bit cd, input logic [1:0] rs, input bit ca, input logic ps);
      exp_t e;
      e.regs  = {mr[mb][3], mr[mb][2], mr[mb][1], mr[mb][0]};
      e.bank  = mb[0];
      e.wrap  = mwrap;
      e.chk_d = cd;
      e.d     = mr[mb][rs];
      e.chk_a = ca;
      e.a     = {mr[mb][2*ps], mr[mb][2*ps+1]};
      q.push_back(e);
   endfunction

   function automatic void model_apply(input stim_t s);
      int          p;
      logic [15:0] pv;
      logic        w;
      p  = int'(s.os);
      pv = {mr[mb][2*p], mr[mb][2*p+1]};
      w  = 1'b0;
      if (s.op != 2'd0 && !(s.we && (int'(s.ws) / 2 == p))) begin
         if (s.op == 2'd1) begin
            w  = (pv == 16'hFFFF);
            pv = pv + 16'd1;
         end else begin
            w  = (pv == 16'h0000);
            pv = pv - 16'd1;
         end
         mr[mb][2*p]   = pv[15:8];
         mr[mb][2*p+1] = pv[7:0];
      end
      if (s.we) begin
         if (!s.src) mr[mb][s.ws] = s.wd;
         else begin
            mr[mb][(int'(s.ws) / 2) * 2]     = s.wa[15:8];
            mr[mb][(int'(s.ws) / 2) * 2 + 1] = s.wa[7:0];
         end
      end
      mwrap = w;
`ifdef K12A_GP_REGFILE_SHADOW_EN
      if (s.sw) mb = 1 - mb;
`endif
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.we = 1'b0; s.src = 1'b0; s.ws = 2'd0; s.wd = 8'h00; s.wa = 16'h0000;
      s.op = 2'd0; s.os = 1'b0; s.sw = 1'b0; s.rde = 1'b0; s.rs = 2'd0;
      s.pre = 1'b0; s.prs = 1'b0;
      return s;
   endfunction

   function automatic stim_t wr_d(input logic [1:0] sel, input logic [7:0] v);
      stim_t s = idle();
      s.we = 1'b1; s.src = 1'b0; s.ws = sel; s.wd = v;
      return s;
   endfunction

   function automatic stim_t wr_a(input logic [1:0] sel, input logic [15:0] v);
      stim_t s = idle();
      s.we = 1'b1; s.src = 1'b1; s.ws = sel; s.wa = v;
      return s;
   endfunction

   function automatic stim_t pop(input logic [1:0] op, input logic sel);
      stim_t s = idle();
      s.op = op; s.os = sel; s.pre = 1'b1; s.prs = sel;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      wr_en        = s.we;
      wr_src       = gp_wr_src_t'(s.src);
      wr_sel       = s.ws;
      pair_op      = gp_pair_op_t'(s.op);
      pair_op_sel  = s.os;
      bank_swap    = s.sw;
      tb_d         = s.wd;
      tb_a         = s.wa;
      tb_d_en      = s.we && !s.src;
      tb_a_en      = s.we && s.src;
      rd_en_n      = !(s.rde && !tb_d_en);
      rd_sel       = s.rs;
      pair_rd_en_n = !(s.pre && !tb_a_en);
      pair_rd_sel  = s.prs;
   endtask

   task automatic step(input stim_t s);
      @(posedge cpu_clock);
      #1;
      drive(s);
      push_exp(!rd_en_n, s.rs, !pair_rd_en_n, s.prs);
      model_apply(s);
   endtask

   // Mid-cycle asynchronous reset pulse, state checked at the following negedge.
   task automatic rst_pulse();
      @(posedge cpu_clock);
      #1;
      drive(idle());
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      model_reset();
      push_exp(1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   // Monitor: compare every presented cycle against the queued expectation.
   always @(negedge cpu_clock) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("regs", regs, e.regs);
         chk("bank", {31'd0, bank}, {31'd0, e.bank});
         chk("pair_wrap", {31'd0, pair_wrap}, {31'd0, e.wrap});
         if (e.chk_d) chk("data_bus", {24'd0, data_bus}, {24'd0, e.d});
         if (e.chk_a) chk("addr_bus", {16'd0, addr_bus}, {16'd0, e.a});
      end
   end

   initial begin
      stim_t s;
      reset_n = 1'b0;
      drive(idle());
      model_reset();
      repeat (2) @(posedge cpu_clock);
      rst_pulse();

      step(wr_d(2'd2, 8'hA5));
      s = idle(); s.rde = 1'b1; s.rs = 2'd2; step(s);
      step(wr_a(2'd3, 16'hFFFF));
      step(pop(2'd1, 1'b1));
      step(pop(2'd0, 1'b1));
      step(pop(2'd0, 1'b1));
      step(wr_a(2'd0, 16'h1200));
      step(pop(2'd2, 1'b0));
      step(pop(2'd0, 1'b0));
      step(wr_a(2'd1, 16'h0010));
      s = wr_d(2'd1, 8'h33); s.op = 2'd1; s.os = 1'b0; step(s);
      step(pop(2'd0, 1'b0));
      s = wr_a(2'd0, 16'h0000); step(s);
      step(pop(2'd2, 1'b0));

      step(wr_d(2'd0, 8'h11));
      s = idle(); s.sw = 1'b1; step(s);
      step(wr_d(2'd0, 8'h22));
      s = idle(); s.sw = 1'b1; step(s);
      s = idle(); s.rde = 1'b1; s.rs = 2'd0; step(s);
      s = wr_d(2'd3, 8'h5C); s.sw = 1'b1; step(s);
      s = idle(); s.rde = 1'b1; s.rs = 2'd3; step(s);

      rst_pulse();
      step(idle());

      for (int n = 0; n < 400; n++) begin
         s.we  = ($urandom_range(0, 2) == 0);
         s.src = $urandom_range(0, 1);
         s.ws  = 2'($urandom_range(0, 3));
         s.wd  = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       s.wa = 16'hFFFF;
            1:       s.wa = 16'h0000;
            default: s.wa = 16'($urandom);
         endcase
         s.op  = 2'($urandom_range(0, 2));
         s.os  = 1'($urandom_range(0, 1));
         s.sw  = ($urandom_range(0, 7) == 0);
         s.rde = $urandom_range(0, 1);
         s.rs  = 2'($urandom_range(0, 3));
         s.pre = $urandom_range(0, 1);
         s.prs = 1'($urandom_range(0, 1));
         step(s);
      end
      step(idle());

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge cpu_clock);
      #1;
      if (q.size() != 0) begin
         total++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/k12a_gp_regfile.md
# k12a_gp_regfile

Parametrised general-purpose register file for the K12A datapath, the successor to the fixed A/B/C/D register block. It holds NUM_REGS registers of DATA_W bits in each of two banks. It drives and samples the shared data and address buses through indexed selects instead of per-register strobes. It adds pair post-increment/decrement with wrap reporting and a single-cycle active-bank swap for fast interrupt context switching.

## Interface
Parameters:
- DATA_W, 8, register width; data bus width.
- NUM_REGS, 4, registers per bank; must be even and ≥2.
- SEL_W, $clog2(NUM_REGS), register select width.
- Derived: ADDR_W = 2*DATA_W (address bus width); NUM_PAIRS = NUM_REGS/2; PSEL_W = max(1,$clog2(NUM_PAIRS)).

Ports:
- cpu_clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_en_n  in  1  active-low; drive data_bus with active-bank reg[rd_sel].
- rd_sel  in  SEL_W  data-bus read select.
- pair_rd_en_n  in  1  active-low; drive addr_bus with active-bank pair[pair_rd_sel].
- pair_rd_sel  in  PSEL_W  address-bus read select.
- wr_en  in  1  write strobe.
- wr_src  in  gp_wr_src_t  GP_WR_DATA_BUS: reg[wr_sel] ← data_bus; GP_WR_ADDR_BUS: pair[wr_sel>>1] ← addr_bus.
- wr_sel  in  SEL_W  write target; LSB ignored for pair writes.
- pair_op  in  gp_pair_op_t  GP_PAIR_NONE / GP_PAIR_INC / GP_PAIR_DEC.
- pair_op_sel  in  PSEL_W  pair operated on.
- bank_swap  in  1  toggle active bank at the clock edge.
- data_bus  inout  DATA_W  shared data bus, tri-stated when not driving.
- addr_bus  inout  ADDR_W  shared address bus, tri-stated when not driving.
- regs  out  NUM_REGS*DATA_W  active-bank contents; reg i at [i*DATA_W +: DATA_W].
- bank  out  1  active bank index.
- pair_wrap  out  1  registered; high for one cycle after an inc/dec that wrapped.

## Operation
- Pair p = {reg[2p], reg[2p+1]}; even register is the high byte.
- Reads are combinational from the active bank. With rd_en_n high, data_bus is Z. With pair_rd_en_n high, addr_bus is Z.
- Write and pair_op act on the bank that is active before the edge.
- INC: pair ← pair+1 mod 2^ADDR_W. DEC: pair ← pair−1 mod 2^ADDR_W. Carry and borrow propagate across the byte boundary.
- pair_wrap ← 1 when INC goes from all-ones to 0 or DEC goes from 0 to all-ones; otherwise 0 on every edge.
- bank_swap: bank ← ~bank. The inactive bank is held unchanged. regs reflects the new bank from the next cycle.
- Simultaneous events:
  - wr_en targeting any byte of the pair_op pair: the write wins, the op is discarded, and pair_wrap=0.
  - Write or op together with bank_swap: the update lands in the old bank, then the swap takes effect.
- Reading and writing the same register in one cycle is legal. The read returns the old value.
- Out-of-range wr_sel, rd_sel or pair selects (non-power-of-two NUM_REGS): writes are ignored, reads return 0.

## Timing
- Reset (async assert, sync-free): both banks all 0, bank=0, pair_wrap=0, bus drivers Z.
- Reset asserted mid-operation aborts any pending update. No partial write survives.
- Write, inc/dec and swap latency: one edge. Effect is visible on regs/bus the following cycle.
- Bus drive: combinational from rd_en_n and pair_rd_en_n. The controller must not enable two bus drivers at once; this block does not arbitrate.

## Configuration
- K12A_GP_REGFILE_SHADOW_EN:
  - Defined: second bank implemented; bank_swap and bank operate as above.
  - Undefined: single bank only; bank_swap ignored, bank tied 0, no shadow storage synthesised.

## Structure
- Shared k12a package/include: gp_wr_src_t, gp_pair_op_t, and the default DATA_W/NUM_REGS constants.
- One sub-module, k12a_gp_pair_incdec: combinational ADDR_W inc/dec with wrap output. Instantiated once and fed by a pair_op_sel mux.

## Test plan
- Reset: pulse reset_n low mid-cycle → regs=0, bank=0, pair_wrap=0, both buses Z.
- Data write/read: write 8'hA5 to reg 2 via data_bus, then rd_sel=2, rd_en_n=0 → data_bus=8'hA5, regs[23:16]=8'hA5.
- Pair load and INC wrap: write addr_bus=16'hFFFF to pair 1, then INC pair 1 → pair 1=16'h0000, pair_wrap=1 for exactly one cycle.
- Byte carry on DEC: pair 0=16'h1200, DEC → 16'h11FF, pair_wrap=0.
- Collision: wr_en to reg 1=8'h33 with INC on pair 0 (was 16'h0010) → pair 0=16'h0033, pair_wrap=0.
- Shadow bank (macro defined): write reg0=8'h11, swap, write reg0=8'h22, swap → regs byte0=8'h11, bank=0. Swap again → 8'h22. Without the macro, bank stays 0 and byte0=8'h22.
